// File: rtl/toggle_pulse_tx.sv
// rtl/toggle_pulse_tx.sv - toggle-handshake request transmitter with pending-event counter
module toggle_pulse_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 15
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       in,
    input  logic       ack_tgl,
    output logic       req_tgl,
    output logic       done,
    output logic       busy,
    output logic [3:0] pending_cnt,
    output logic       overflow
);

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    logic                   req_nxt;
    logic                   done_nxt;
    logic                   ovf_nxt;
    logic [3:0]             cnt_nxt;
    logic                   issue;
    logic                   accept;

    // Only the last synchronizer stage is safe to use; earlier stages may be metastable.
    assign ack_s = sync[SYNC_STAGES-1];

    // Synchronizer chain bringing the destination's ack toggle into clk1.
    always_ff @(posedge clk1) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ack_tgl};
        end
    end

    // Handshake sequencing and pending-event accounting; every registered output is computed here.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_tgl;
        done_nxt  = 1'b0;
        ovf_nxt   = overflow;
        cnt_nxt   = pending_cnt;
        issue     = 1'b0;

        case (state)
            IDLE: begin
                if (pending_cnt != 4'd0) begin
                    issue     = 1'b1;
                    req_nxt   = ~req_tgl;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // The toggle is acknowledged once the synchronized ack catches up with req_tgl.
                if (ack_s == req_tgl) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A full counter can still accept an event when one leaves on the same edge.
        accept = in && ((pending_cnt < DEPTH_L) || issue);
        if (in && !accept) begin
            ovf_nxt = 1'b1;
        end

        if (accept && !issue) begin
            cnt_nxt = pending_cnt + 4'd1;
        end else if (!accept && issue) begin
            cnt_nxt = pending_cnt - 4'd1;
        end
    end

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state       <= IDLE;
            req_tgl     <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            pending_cnt <= 4'd0;
        end else begin
            state       <= state_nxt;
            req_tgl     <= req_nxt;
            done        <= done_nxt;
            overflow    <= ovf_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    assign busy = (state == WAIT) || (pending_cnt != 4'd0);

endmodule

// File: tb/tb_toggle_pulse_tx.sv
// tb/tb_toggle_pulse_tx.sv - randomized model-checked bench for toggle_pulse_tx
module tb_toggle_pulse_tx;

    localparam int SYNC  = 2;
    localparam int DEPTH = 15;

    logic       clk1    = 1'b0;
    logic       reset   = 1'b1;
    logic       in      = 1'b0;
    logic       ack_tgl = 1'b0;
    logic       req_tgl;
    logic       done;
    logic       busy;
    logic [3:0] pending_cnt;
    logic       overflow;

    toggle_pulse_tx #(
        .SYNC_STAGES(SYNC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk1       (clk1),
        .reset      (reset),
        .in         (in),
        .ack_tgl    (ack_tgl),
        .req_tgl    (req_tgl),
        .done       (done),
        .busy       (busy),
        .pending_cnt(pending_cnt),
        .overflow   (overflow)
    );

    always #5 clk1 = ~clk1;

    int checks   = 0;
    int failures = 0;

    // Reference model state: events owed, whether a request is outstanding, last request level.
    int m_pend = 0;
    bit m_fly  = 1'b0;
    bit m_req  = 1'b0;
    bit m_done = 1'b0;
    bit m_ovf  = 1'b0;
    bit m_hist[$];

    // Bench-side destination and bookkeeping.
    bit chk_en     = 1'b0;
    bit loop_en    = 1'b0;
    int loop_delay = 0;
    int dly_cnt    = 0;
    int n_tgl      = 0;
    int n_done     = 0;
    int peak       = 0;
    bit prev_req   = 1'b0;
    int rate       = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ack seen SYNC edges late, one request outstanding, bounded owed-event count.
    always @(posedge clk1) begin
        bit a_s;
        bit issue;
        bit accept;
        if (reset) begin
            m_pend = 0;
            m_fly  = 1'b0;
            m_req  = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_hist = {};
            for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        end else begin
            a_s = m_hist.pop_front();
            m_hist.push_back(ack_tgl);
            issue  = !m_fly && (m_pend > 0);
            m_done = m_fly && (a_s == m_req);
            if (m_done) m_fly = 1'b0;
            accept = in && ((m_pend < DEPTH) || issue);
            if (in && !accept) m_ovf = 1'b1;
            if (issue) begin
                m_req  = !m_req;
                m_fly  = 1'b1;
                m_pend = m_pend - 1;
            end
            if (accept) m_pend = m_pend + 1;
        end
    end

    // One clock: compare outputs with the model, run the destination echo, then drive in.
    task automatic tick(input bit in_val);
        @(negedge clk1);
        if (chk_en) begin
            check("req_tgl", req_tgl, m_req);
            check("done", done, m_done);
            check("pending_cnt", pending_cnt, m_pend);
            check("overflow", overflow, m_ovf);
            check("busy", busy, (m_fly || m_pend != 0) ? 1 : 0);
        end
        if (req_tgl != prev_req) n_tgl++;
        prev_req = req_tgl;
        if (done) n_done++;
        if (int'(pending_cnt) > peak) peak = pending_cnt;
        if (loop_en) begin
            if (ack_tgl != req_tgl) begin
                dly_cnt++;
                if (dly_cnt > loop_delay) begin
                    ack_tgl = req_tgl;
                    dly_cnt = 0;
                end
            end else begin
                dly_cnt = 0;
            end
        end
        in = in_val;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ack_tgl = 1'b0;
        dly_cnt = 0;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        n_tgl  = 0;
        n_done = 0;
        peak   = 0;
    endtask

    initial begin
        repeat (2) tick(1'b0);
        chk_en = 1'b1;
        do_reset();

        // Reset state
        check("rst_req_tgl", req_tgl, 0);
        check("rst_done", done, 0);
        check("rst_pending", pending_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // Single event with looped-back ack
        clear_counts();
        loop_en    = 1'b1;
        loop_delay = 3;
        tick(1'b1);
        tick(1'b0);
        check("single_pend_after_N", pending_cnt, 1);
        check("single_req_after_N", req_tgl, 0);
        tick(1'b0);
        check("single_req_after_N1", req_tgl, 1);
        check("single_pend_after_N1", pending_cnt, 0);
        check("single_busy_inflight", busy, 1);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (!busy && n_done > 0) break;
        end
        check("single_done_count", n_done, 1);
        check("single_toggle_count", n_tgl, 1);
        check("single_busy_end", busy, 0);
        check("single_pend_end", pending_cnt, 0);

        // Burst of five
        do_reset();
        clear_counts();
        loop_delay = 3;
        repeat (5) tick(1'b1);
        for (int i = 0; i < 200; i++) begin
            tick(1'b0);
            if (!busy && n_done >= 5) break;
        end
        check("burst_toggles", n_tgl, 5);
        check("burst_dones", n_done, 5);
        check("burst_overflow", overflow, 0);
        check("burst_peak", peak, 4);

        // Overflow with ack frozen
        do_reset();
        clear_counts();
        loop_en = 1'b0;
        repeat (17) tick(1'b1);
        tick(1'b0);
        check("ovf_pending", pending_cnt, 15);
        check("ovf_flag", overflow, 1);
        check("ovf_toggles", n_tgl, 1);
        repeat (10) tick(1'b0);
        check("ovf_no_more_toggles", n_tgl, 1);
        check("ovf_sticky", overflow, 1);
        check("ovf_busy", busy, 1);

        // Event arriving on the same edge as an issue with pending_cnt=3
        do_reset();
        clear_counts();
        repeat (4) tick(1'b1);
        tick(1'b0);
        check("simul_pend_before", pending_cnt, 3);
        ack_tgl = req_tgl;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (done) break;
        end
        check("simul_done_seen", n_done, 1);
        in = 1'b1;
        tick(1'b0);
        check("simul_pend_after", pending_cnt, 3);
        check("simul_req_toggled", req_tgl, 0);

        // Reset while waiting with two pending
        do_reset();
        clear_counts();
        repeat (3) tick(1'b1);
        tick(1'b0);
        check("midrst_pend_before", pending_cnt, 2);
        check("midrst_busy_before", busy, 1);
        reset   = 1'b1;
        ack_tgl = 1'b0;
        tick(1'b0);
        check("midrst_req", req_tgl, 0);
        check("midrst_done", done, 0);
        check("midrst_pend", pending_cnt, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        repeat (6) tick(1'b0);
        check("midrst_no_done", n_done, 0);

        // Spurious ack toggle while idle
        clear_counts();
        ack_tgl = 1'b1;
        repeat (6) tick(1'b0);
        check("spur_no_done", n_done, 0);
        check("spur_no_toggle", n_tgl, 0);
        check("spur_busy", busy, 0);
        ack_tgl = 1'b0;
        repeat (4) tick(1'b0);

        // Randomized traffic against the model
        do_reset();
        loop_en = 1'b1;
        for (int blk = 0; blk < 16; blk++) begin
            loop_delay = $urandom_range(0, 6);
            rate       = $urandom_range(1, 9);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    tick($urandom_range(0, 9) < rate);
                end
            end
        end
        for (int i = 0; i < 600; i++) begin
            tick(1'b0);
            if (!busy) break;
        end
        check("random_drain_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_tx.md
TOGGLE_PULSE_TX -- requirements
Module: toggle_pulse_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing ack_tgl (legal range 2..4).
REQ-002 SHALL have parameter DEPTH, default 15, maximum pending requests held (legal range 1..15).
REQ-003 SHALL have port clk1  input  1  source-domain clock; the only clock of the block.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset sampled on posedge clk1.
REQ-005 SHALL have port in  input  1  request pulse; each clk1 cycle with in=1 is one event.
REQ-006 SHALL have port ack_tgl  input  1  acknowledge toggle from destination domain, asynchronous to clk1.
REQ-007 SHALL have port req_tgl  output  1  registered request toggle sent to destination domain.
REQ-008 SHALL have port done  output  1  one-cycle pulse when an issued request is acknowledged.
REQ-009 SHALL have port busy  output  1  high while any request is pending or in flight.
REQ-010 SHALL have port pending_cnt  output  4  events accepted but not yet issued.
REQ-011 SHALL have port overflow  output  1  sticky flag, set when an event is dropped.

Function
REQ-012 SHALL pass ack_tgl through SYNC_STAGES flops on clk1; only the last stage (ack_s) SHALL be used by logic.
REQ-013 SHALL implement FSM states IDLE and WAIT.
REQ-014 IDLE with pending_cnt>0 at a posedge SHALL invert req_tgl, decrement pending_cnt and enter WAIT on that edge.
REQ-015 IDLE with pending_cnt=0 SHALL hold req_tgl and state; an in pulse in that cycle only increments pending_cnt.
REQ-016 WAIT with ack_s==req_tgl SHALL return to IDLE and assert done for exactly the following cycle.
REQ-017 WAIT with ack_s!=req_tgl SHALL hold; no timeout.
REQ-018 in=1 with pending_cnt<DEPTH SHALL increment pending_cnt at that edge.
REQ-019 in=1 and an issue (REQ-014) on the same edge SHALL leave pending_cnt unchanged; no event is lost.
REQ-020 in=1 with pending_cnt==DEPTH and no simultaneous issue SHALL drop the event, hold pending_cnt, and set overflow.
REQ-021 overflow SHALL stay set until reset.
REQ-022 pending_cnt SHALL never exceed DEPTH or wrap below 0.
REQ-023 busy SHALL be combinational: (state==WAIT) or (pending_cnt!=0).
REQ-024 Latency: in=1 at edge N with block idle -> req_tgl toggles at edge N+1; done rises one edge after ack_s matches.
REQ-025 Only one request SHALL be in flight; req_tgl SHALL not toggle again until done for the prior toggle.
REQ-026 An ack_tgl change while in IDLE (spurious) SHALL be ignored, with no state change and no done.
REQ-027 req_tgl, done and overflow SHALL be driven directly from flops.

Reset
REQ-028 reset=1 at a posedge SHALL force state=IDLE, req_tgl=0, done=0, pending_cnt=0, overflow=0, and all sync flops=0, regardless of state.
REQ-029 Reset mid-WAIT SHALL abandon the in-flight request without a done pulse; the destination side is reset together with this block.
REQ-030 in SHALL be ignored on any edge where reset=1.
REQ-031 After reset deasserts, busy=0 and the first accepted in pulse SHALL behave per REQ-024.

Verification
REQ-032 Single event: after reset, in=1 for 1 cycle, ack_tgl mirrors req_tgl 3 cycles later -> req_tgl 0->1 next edge, done=1 one cycle, and pending_cnt and busy both return to 0.
REQ-033 Burst: 5 consecutive in=1 cycles with ack looped back with delay -> exactly 5 req_tgl toggles, 5 done pulses, overflow=0, pending_cnt peaks at 4.
REQ-034 Overflow: DEPTH=15, ack_tgl held constant, 17 in pulses -> 1 in flight, pending_cnt=15, overflow=1, and there are no further toggles.
REQ-035 Simultaneous: in=1 on the same edge an issue occurs with pending_cnt=3 -> pending_cnt stays 3.
REQ-036 Reset mid-operation: reset in WAIT with pending_cnt=2 -> next cycle all outputs 0, and there is no done pulse.
REQ-037 Spurious ack: toggle ack_tgl while IDLE -> no done, no req_tgl change, and busy stays 0.
